// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Message-granular round-robin arbiter sharing one uart_tx
//                byte channel between NUM_REQ byte-stream requesters. A grant
//                lasts for a whole message (terminated by req_last), so
//                messages never interleave. Output is a registered
//                valid/ready stage matching the uart_tx handshake.
//                Optional stall watchdog: define UART_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_data_valid,
    input  logic                   tx_data_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int                 c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned        c_num   = NUM_REQ;
    localparam logic [NUM_REQ-1:0] c_one   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_xfer  = 2'd1,
        c_st_drain = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_idx_w-1:0]    r_ptr;
    logic [c_idx_w-1:0]    r_owner;
    logic [c_idx_w-1:0]    w_pick;
    logic [NUM_REQ-1:0]    r_grant;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;
    logic [7:0]            w_req_byte [NUM_REQ];

    logic                  w_out_free;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic                  w_hs;
    logic                  w_any_req;

    // Control strobes from the FSM to the datapath register
    logic                  w_arb;
    logic                  w_load;
    logic                  w_drop_valid;
    logic                  w_release;
    logic                  w_ptr_adv;

    // (base + off) modulo NUM_REQ, valid for off < NUM_REQ
    function automatic logic [c_idx_w-1:0] f_wrap_add(input logic [c_idx_w-1:0] base,
                                                      input int unsigned        off);
        int unsigned sum;
        sum = int'(base) + off;
        if (sum >= c_num) begin
            sum = sum - c_num;
        end
        return sum[c_idx_w-1:0];
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_byte[gi] = req_data[8*gi +: 8];
    end

    assign w_out_free    = !r_tx_valid || tx_data_ready;
    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_hs          = (r_state == c_st_xfer) && w_owner_valid && w_out_free;
    assign w_any_req     = |req_valid;

    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign grant         = r_grant;
    assign busy          = (r_state != c_st_idle);

    // Round-robin pick: first valid requester at or above ptr, with wrap
    always_comb begin
        w_pick = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[f_wrap_add(r_ptr, k)]) begin
                w_pick = f_wrap_add(r_ptr, k);
            end
        end
    end

    // Only the owner may be ready, and only while the output stage can take a byte
    always_comb begin
        req_ready = '0;
        if (r_state == c_st_xfer) begin
            req_ready[r_owner] = w_out_free;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [31:0] c_stall_last = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] r_stall;
    logic        r_timeout_err;
    logic        w_stalling;
    logic        w_stall_expired;

    // The owner is stalling when it has nothing in flight and nothing offered
    assign w_stalling      = (r_state == c_st_xfer) && !r_tx_valid && !w_owner_valid;
    assign w_stall_expired = w_stalling && (r_stall == c_stall_last);
    assign timeout_err     = r_timeout_err;

    // Stall counter, restarted by any owner byte or by leaving XFER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_stall_expired;
            if ((r_state != c_st_xfer) || w_hs) begin
                r_stall <= '0;
            end else if (w_stalling) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_arb        = 1'b0;
        w_load       = 1'b0;
        w_drop_valid = 1'b0;
        w_release    = 1'b0;
        w_ptr_adv    = 1'b0;
        unique case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_arb        = 1'b1;
                    w_state_next = c_st_xfer;
                end
            end
            c_st_xfer: begin
                if (w_hs) begin
                    w_load = 1'b1;
                    if (w_owner_last) begin
                        w_ptr_adv    = 1'b1;
                        w_state_next = c_st_drain;
                    end
                end else if (r_tx_valid && tx_data_ready) begin
                    w_drop_valid = 1'b1;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (w_stall_expired) begin
                    // Abandon the partial message; no terminator is inserted
                    w_release    = 1'b1;
                    w_ptr_adv    = 1'b1;
                    w_state_next = c_st_idle;
                end
`endif
            end
            c_st_drain: begin
                if (r_tx_valid && tx_data_ready) begin
                    w_drop_valid = 1'b1;
                    w_release    = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Grant, round-robin pointer and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_arb) begin
                r_grant <= c_one << w_pick;
                r_owner <= w_pick;
            end
            if (w_release) begin
                r_grant <= '0;
            end
            if (w_ptr_adv) begin
                r_ptr <= f_wrap_add(r_owner, 1);
            end
            if (w_load) begin
                r_tx_data  <= w_req_byte[r_owner];
                r_tx_valid <= 1'b1;
            end else if (w_drop_valid) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. Per-requester source
//                queues feed the DUT; expected bytes (with expected owner) go
//                to a scoreboard queue and are popped at each output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        logic [7:0] data;
        logic [3:0] grant;
        logic       last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready = 1'b0;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_err;

    exp_t       sb[$];
    logic [8:0] src_q[NUM_REQ][$];
    int         out_cyc[$];
    exp_t       m_e;
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_out = 0;
    int         tmo_count = 0;
    int         tmo_cyc = 0;
    logic [3:0] acc = '0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       idle_chk = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [3:0] g, input logic last);
        exp_t e;
        e.data  = d;
        e.grant = g;
        e.last  = last;
        sb.push_back(e);
    endtask

    function automatic logic all_empty();
        logic r;
        r = (sb.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic clear_queues();
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_data_valid), 0);
        chk({tag, "_tx_data"},  32'(tx_data), 0);
        chk({tag, "_grant"},    32'(grant), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_timeout"},  32'(timeout_err), 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_reset(tag);
        clear_queues();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && !busy) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(all_empty() && !busy), 1);
    endtask

    // Requester sources: retire the byte accepted last cycle, present the next
    always @(posedge clk) begin
        #1;
        if (rst) begin
            req_valid = '0;
            req_last  = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare and per-cycle protocol checks
    always @(negedge clk) begin
        cyc++;
        acc = req_valid & req_ready;
        if (rst) begin
            prev_stall = 1'b0;
            idle_chk   = 1'b0;
        end else begin
            if (idle_chk) begin
                chk("idle_after_last", {27'd0, busy, grant}, 0);
                idle_chk = 1'b0;
            end
            if (prev_stall) chk("hold_data", {23'd0, tx_data_valid, tx_data}, {23'd0, 1'b1, prev_data});
            chk("nonowner_ready", 32'(req_ready & ~grant), 0);
            if (tx_data_valid && !tx_data_ready) chk("ready_in_stall", 32'(req_ready), 0);
            if (timeout_err) begin
                tmo_count++;
                tmo_cyc = cyc;
                chk("grant_at_timeout", {27'd0, busy, grant}, 0);
            end
            if (tx_data_valid && tx_data_ready) begin
                n_out++;
                out_cyc.push_back(cyc);
                chk("byte_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    m_e = sb.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(m_e.data));
                    chk("grant_on_byte", 32'(grant), 32'(m_e.grant));
                    if (m_e.last) idle_chk = 1'b1;
                end
            end
            prev_stall = tx_data_valid && !tx_data_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [3:0] pat;

        // Power-on reset
        rst = 1'b1;
        repeat (3) step();
        chk_reset("por");
        rst = 1'b0;
        tx_data_ready = 1'b1;
        step();

        // Single requester, "Hi\r\n" back to back
        out_cyc.delete();
        push_src(1, 8'h48, 0); push_src(1, 8'h69, 0); push_src(1, 8'h0D, 0); push_src(1, 8'h0A, 1);
        push_exp(8'h48, 4'b0010, 0); push_exp(8'h69, 4'b0010, 0);
        push_exp(8'h0D, 4'b0010, 0); push_exp(8'h0A, 4'b0010, 1);
        wait_done("t1_done", 100);
        chk("t1_count", 32'(out_cyc.size()), 4);
        if (out_cyc.size() == 4) chk("t1_back_to_back", 32'(out_cyc[3] - out_cyc[0]), 3);

        // Contention from reset: req0 first, then req2, then req0's second message
        pulse_reset("rst2");
        push_src(0, 8'h41, 0); push_src(0, 8'h41, 0); push_src(0, 8'h41, 1);
        push_src(0, 8'h61, 0); push_src(0, 8'h61, 0); push_src(0, 8'h61, 1);
        push_src(2, 8'h43, 0); push_src(2, 8'h43, 0); push_src(2, 8'h43, 1);
        for (int i = 0; i < 3; i++) push_exp(8'h41, 4'b0001, i == 2);
        for (int i = 0; i < 3; i++) push_exp(8'h43, 4'b0100, i == 2);
        for (int i = 0; i < 3; i++) push_exp(8'h61, 4'b0001, i == 2);
        wait_done("t2_done", 200);

        // Backpressure with ready pattern 1,0,0,1
        for (int i = 0; i < 4; i++) begin
            push_src(3, 8'(8'h10 + i), i == 3);
            push_exp(8'(8'h10 + i), 4'b1000, i == 3);
        end
        pat = 4'b1001;
        for (int c = 0; c < 200; c++) begin
            if (all_empty() && !busy) break;
            tx_data_ready = pat[c % 4];
            step();
        end
        tx_data_ready = 1'b1;
        chk("t3_done", 32'(all_empty() && !busy), 1);

        // One-byte message
        push_src(1, 8'h55, 1);
        push_exp(8'h55, 4'b0010, 1);
        wait_done("t4_done", 50);

`ifdef UART_ARB_TIMEOUT_EN
        // Owner stalls mid-message; waiting req1 is served after the timeout
        out_cyc.delete();
        tmo_count = 0;
        push_src(0, 8'h77, 0);
        push_src(1, 8'h31, 1);
        push_exp(8'h77, 4'b0001, 0);
        push_exp(8'h31, 4'b0010, 1);
        wait_done("t5_done", 200);
        chk("t5_timeout_pulses", 32'(tmo_count), 1);
        if (out_cyc.size() >= 1) chk("t5_timeout_latency", 32'(tmo_cyc - out_cyc[0]), 17);
`endif

        // Reset in the middle of a 5-byte message
        for (int i = 0; i < 5; i++) begin
            push_src(2, 8'(8'h80 + i), i == 4);
            push_exp(8'(8'h80 + i), 4'b0100, i == 4);
        end
        base = n_out;
        for (int c = 0; c < 50 && n_out < base + 1; c++) step();
        chk("t6_first_byte_out", 32'(n_out - base), 1);
        rst = 1'b1;
        #1;
        chk_reset("mid");
        clear_queues();
        step();
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("t6_no_residual", 32'(n_out - base), 1);
        chk("t6_idle", {27'd0, busy, grant}, 0);

        // Pointer restored to 0 by reset: req0 beats req3
        push_src(3, 8'h03, 1);
        push_src(0, 8'h01, 1);
        push_exp(8'h01, 4'b0001, 1);
        push_exp(8'h03, 4'b1000, 1);
        wait_done("t7_done", 50);

`ifndef UART_ARB_TIMEOUT_EN
        chk("no_timeout_pulse", 32'(tmo_count), 0);
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Message-granular round-robin arbiter that shares one `uart_tx` byte channel between `NUM_REQ` requesters. It sits between byte-stream producers (banner generator, RX echo path, debug/status reporters) and the `uart_tx` instance. It grants the channel to one requester for an entire message, delimited by `req_last`, so messages are never interleaved. The output is a registered valid/ready stage that matches the `tx_data`/`tx_data_valid`/`tx_data_ready` handshake of `uart_tx`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 200000000: stall limit for a granted requester; used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_data`  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i presents a byte.
- `req_last`  in  NUM_REQ  byte from requester i is the last one of its message.
- `req_ready`  out  NUM_REQ  combinational; byte from requester i is accepted this cycle.
- `tx_data`  out  8  byte to `uart_tx`.
- `tx_data_valid`  out  1  output register holds a byte.
- `tx_data_ready`  in  1  `uart_tx` accepts the byte.
- `grant`  out  NUM_REQ  one-hot owner of the channel; all zero when idle.
- `busy`  out  1  high in XFER or DRAIN.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- State machine states:
  - IDLE: `grant`=0, all `req_ready`=0. When any `req_valid` bit is set, pick the first set bit searching upward from `ptr` with wrap. Set `grant` to that one-hot and `owner` to its index, then go to XFER. If no `req_valid` bit is set, stay in IDLE.
  - XFER:
    - `req_ready[owner] = (!tx_data_valid || tx_data_ready)`. Every other `req_ready` bit is 0.
    - On an owner handshake, load `tx_data <= req_data[owner]` and set `tx_data_valid` to 1.
    - If the output is being emptied and there is no owner handshake, clear `tx_data_valid`.
    - An owner handshake with `req_last[owner]` set moves the FSM to DRAIN and sets `ptr <= owner+1` (mod NUM_REQ).
  - DRAIN: all `req_ready` bits are 0. When `tx_data_valid && tx_data_ready`, clear `tx_data_valid`, clear `grant`, and go to IDLE.
- `ptr` is the round-robin start index. Reset value is 0, so requester 0 has top priority after reset.
- `req_last` is ignored when `req_valid` is low. A one-byte message (valid and last together) goes XFER→DRAIN after one handshake.
- Requesters without the grant are never stalled combinationally by one another. Their `req_valid` may stay high indefinitely.
- `req_valid` dropping mid-message is legal. The grant is held, and the arbiter waits for the owner to resume.
- `tx_data` holds its value whenever `tx_data_valid` is high and `tx_data_ready` is low.
- `busy` = (state != IDLE).

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) sets: state IDLE, `ptr`=0, `tx_data`=0, `tx_data_valid`=0, `req_ready`=0, `grant`=0, `busy`=0, `timeout_err`=0.
- Reset asserted mid-message: the partial message is dropped and the output byte is lost. There is no recovery beyond restart.
- Arbitration latency: `req_valid` seen in IDLE in cycle N gives `grant`/`busy` high in N+1. The earliest `req_ready` is in cycle N+1.
- Byte latency: an owner handshake in cycle M gives `tx_data_valid` high in M+1.
- Throughput: one byte per cycle when `tx_data_ready` is held high.
- Message turnaround: the last byte is accepted by `uart_tx` in cycle K, giving IDLE in K+1. The next grant is in K+2.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 32-bit stall counter runs in XFER. It increments while `tx_data_valid`=0 and `req_valid[owner]`=0, and clears on any owner handshake.
  - When the counter reaches `TIMEOUT_CYCLES`: pulse `timeout_err` for one cycle, clear `grant`, set `ptr <= owner+1`, and go to IDLE. The partial message is abandoned with no terminator inserted.
- `UART_ARB_TIMEOUT_EN` not defined:
  - No counter is built.
  - `timeout_err` is tied to 0.
  - A stalled owner holds the channel indefinitely.

## Test plan
- Single requester: req1 sends "Hi\r\n" (last on "\n") with `tx_data_ready`=1. Expect `tx_data` = 0x48, 0x69, 0x0D, 0x0A on four consecutive cycles, `grant`=4'b0010 throughout, and IDLE two cycles after the final byte.
- Contention: req0 and req2 both send 3-byte messages "AAA" and "CCC" from cycle 0 after reset. Expect the "AAA" bytes before the "CCC" bytes with no interleave. Then re-assert both: expect order req2 then req0, since `ptr` now points past req0.
- Backpressure: `tx_data_ready` toggles 1,0,0,1 while req3 streams 0x10..0x13. Expect `tx_data` stable while ready is 0 and `req_ready[3]` low in those cycles. All four bytes must arrive in order.
- One-byte message: req1 asserts valid+last with data 0x55 for one cycle. Expect XFER→DRAIN→IDLE, a single 0x55 on the output, and `grant` cleared.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): req0 sends one non-last byte, then drops valid. Expect a `timeout_err` pulse 16 cycles after the output empties, `grant`=0, and waiting req1 granted next.
- Mid-message reset: assert `rst` during byte 2 of a 5-byte message. Expect all outputs at their reset values the same cycle and no residual bytes after release.
